// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 framebuffer blocks: register map, CTRL bit
// positions and the rectangle-fill FSM state encoding.
package hub75_pkg;

    // Register index, taken from addr[3:2]
    localparam logic [1:0] RegPos   = 2'd0;
    localparam logic [1:0] RegSize  = 2'd1;
    localparam logic [1:0] RegColor = 2'd2;
    localparam logic [1:0] RegCtrl  = 2'd3;

    // CTRL bit positions (write: start/buf/swap, read: busy/buf/swap/done)
    localparam int unsigned CtrlStartBit = 0;
    localparam int unsigned CtrlBusyBit  = 0;
    localparam int unsigned CtrlBufBit   = 1;
    localparam int unsigned CtrlSwapBit  = 2;
    localparam int unsigned CtrlDoneBit  = 8;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StIssue     = 3'd1,
        StWait      = 3'd2,
        StSwapIssue = 3'd3,
        StSwapWait  = 3'd4,
        StFinish    = 3'd5
    } state_e;

endpackage

// File: rtl/hub75_fb_addr.sv
// Framebuffer byte address of pixel (x, y) in buffer i_buf.
module hub75_fb_addr #(
    parameter int unsigned ROWS    = 64,
    parameter int unsigned COLS    = 64,
    parameter logic [31:0] FB_BASE = 32'h8100_0000
) (
    input  logic        i_buf,
    input  logic [7:0]  i_x,
    input  logic [7:0]  i_y,
    output logic [31:0] o_addr
);

    logic [31:0] w_plane;
    logic [31:0] w_index;

    // Word index within the driver's two-plane framebuffer, scaled to bytes
    always_comb begin
        w_plane = i_buf ? 32'(ROWS * COLS) : 32'd0;
        w_index = w_plane + 32'(i_y) * 32'(COLS) + 32'(i_x);
        o_addr  = FB_BASE + (w_index << 2);
    end

endmodule

// File: rtl/hub75_rect_fill.sv
// Rectangle fill engine: a small register block on the slave bus; a command
// writes one framebuffer word per pixel of the clipped rectangle through the
// master port, optionally followed by a buffer-swap write, then pulses done.
module hub75_rect_fill
    import hub75_pkg::*;
#(
    parameter int unsigned ROWS     = 64,
    parameter int unsigned COLS     = 64,
    parameter logic [31:0] FB_BASE  = 32'h8100_0000,
    parameter logic [31:0] REG_BASE = 32'h8200_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    // register slave
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        active,
    // framebuffer driver master
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wmask,
    output logic        m_wen,
    input  logic        m_ready,
    output logic        done
);

    localparam logic [31:0] SwapAddr = FB_BASE + 32'(8 * ROWS * COLS);

    state_e      r_state;
    state_e      w_state_d;
    logic [7:0]  r_x0, r_y0, r_w, r_h;
    logic [7:0]  r_x, r_y;
    logic [23:0] r_color;
    logic        r_buf, r_swap, r_done_sticky;
    logic [31:0] r_rdata;
    logic        r_ready;

    logic [1:0]  w_idx;
    logic        w_wr, w_rd, w_busy, w_start, w_empty, w_step;
    logic [8:0]  w_x_sum, w_y_sum, w_x_end, w_y_end, w_x_nxt, w_y_nxt;
    logic        w_last_col, w_last_row;
    logic [31:0] w_pix_addr, w_rd_val, w_ctrl_val;
    logic        w_unused;

    // 33-bit compare so a REG_BASE near the top of the map cannot wrap
    assign active = ({1'b0, addr} >= {1'b0, REG_BASE}) &&
                    ({1'b0, addr} < ({1'b0, REG_BASE} + 33'd16));
    assign w_idx    = addr[3:2];
    assign w_wr     = active & wen;
    assign w_rd     = active & ren;
    assign w_busy   = (r_state != StIdle);
    assign w_start  = w_wr && (w_idx == RegCtrl) && wdata[CtrlStartBit] && !w_busy;
    assign rdata    = r_rdata;
    assign ready    = r_ready;
    assign w_unused = ^{wdata[31:24], wmask[3]};

    // Clipped rectangle bounds and end-of-row / end-of-rect detection
    always_comb begin
        w_x_sum    = {1'b0, r_x0} + {1'b0, r_w};
        w_y_sum    = {1'b0, r_y0} + {1'b0, r_h};
        w_x_end    = (w_x_sum > 9'(COLS)) ? 9'(COLS) : w_x_sum;
        w_y_end    = (w_y_sum > 9'(ROWS)) ? 9'(ROWS) : w_y_sum;
        // also covers w=0, h=0 and an origin outside the panel
        w_empty    = (w_x_end <= {1'b0, r_x0}) || (w_y_end <= {1'b0, r_y0});
        w_x_nxt    = {1'b0, r_x} + 9'd1;
        w_y_nxt    = {1'b0, r_y} + 9'd1;
        w_last_col = (w_x_nxt >= w_x_end);
        w_last_row = (w_y_nxt >= w_y_end);
    end

    hub75_fb_addr #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .FB_BASE (FB_BASE)
    ) u_fb_addr (
        .i_buf  (r_buf),
        .i_x    (r_x),
        .i_y    (r_y),
        .o_addr (w_pix_addr)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state and master-port outputs; outputs hold through the WAIT states
    always_comb begin
        w_state_d = r_state;
        m_wen     = 1'b0;
        m_addr    = 32'd0;
        m_wdata   = 32'd0;
        m_wmask   = 4'd0;
        done      = 1'b0;
        w_step    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    if (!w_empty)                w_state_d = StIssue;
                    else if (wdata[CtrlSwapBit]) w_state_d = StSwapIssue;
                    else                         w_state_d = StFinish;
                end
            end
            StIssue: begin
                m_wen     = 1'b1;
                m_addr    = w_pix_addr;
                m_wdata   = {8'd0, r_color};
                m_wmask   = 4'b0111;
                w_state_d = StWait;
            end
            StWait: begin
                m_addr  = w_pix_addr;
                m_wdata = {8'd0, r_color};
                m_wmask = 4'b0111;
                if (m_ready) begin
                    w_step = 1'b1;
                    if (w_last_col && w_last_row) begin
                        w_state_d = r_swap ? StSwapIssue : StFinish;
                    end else begin
                        w_state_d = StIssue;
                    end
                end
            end
            StSwapIssue: begin
                m_wen     = 1'b1;
                m_addr    = SwapAddr;
                m_wdata   = {31'd0, r_buf};
                m_wmask   = 4'b1111;
                w_state_d = StSwapWait;
            end
            StSwapWait: begin
                m_addr  = SwapAddr;
                m_wdata = {31'd0, r_buf};
                m_wmask = 4'b1111;
                if (m_ready) w_state_d = StFinish;
            end
            StFinish: begin
                done      = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Pixel cursor: loaded on start, stepped row-major on each completed write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= 8'd0;
            r_y <= 8'd0;
        end else if (w_start) begin
            r_x <= r_x0;
            r_y <= r_y0;
        end else if (w_step) begin
            if (w_last_col) begin
                r_x <= r_x0;
                r_y <= r_y + 8'd1;
            end else begin
                r_x <= r_x + 8'd1;
            end
        end
    end

    // Register writes, locked out while a command runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x0    <= 8'd0;
            r_y0    <= 8'd0;
            r_w     <= 8'd0;
            r_h     <= 8'd0;
            r_color <= 24'd0;
            r_buf   <= 1'b0;
            r_swap  <= 1'b0;
        end else if (w_wr && !w_busy) begin
            unique case (w_idx)
                RegPos: begin
                    if (wmask[0]) r_x0 <= wdata[7:0];
                    if (wmask[1]) r_y0 <= wdata[15:8];
                end
                RegSize: begin
                    if (wmask[0]) r_w <= wdata[7:0];
                    if (wmask[1]) r_h <= wdata[15:8];
                end
                RegColor: begin
                    if (wmask[0]) r_color[7:0]   <= wdata[7:0];
                    if (wmask[1]) r_color[15:8]  <= wdata[15:8];
                    if (wmask[2]) r_color[23:16] <= wdata[23:16];
                end
                RegCtrl: begin
                    if (wdata[CtrlStartBit]) begin
                        r_buf  <= wdata[CtrlBufBit];
                        r_swap <= wdata[CtrlSwapBit];
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky completion flag; a finishing command wins over a clearing read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_sticky <= 1'b0;
        end else if (r_state == StFinish) begin
            r_done_sticky <= 1'b1;
        end else if (w_rd && (w_idx == RegCtrl)) begin
            r_done_sticky <= 1'b0;
        end
    end

    // Read data mux
    always_comb begin
        w_ctrl_val              = 32'd0;
        w_ctrl_val[CtrlBusyBit] = w_busy;
        w_ctrl_val[CtrlBufBit]  = r_buf;
        w_ctrl_val[CtrlSwapBit] = r_swap;
        w_ctrl_val[CtrlDoneBit] = r_done_sticky;
        w_rd_val                = 32'd0;
        unique case (w_idx)
            RegPos:   w_rd_val = {16'd0, r_y0, r_x0};
            RegSize:  w_rd_val = {16'd0, r_h, r_w};
            RegColor: w_rd_val = {8'd0, r_color};
            RegCtrl:  w_rd_val = w_ctrl_val;
            default:  w_rd_val = 32'd0;
        endcase
    end

    // Slave response registered one cycle after the request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= active & (ren | wen);
            r_rdata <= w_rd ? w_rd_val : 32'd0;
        end
    end

endmodule

// File: tb/tb_hub75_rect_fill.sv
// Self-checking bench for hub75_rect_fill: table of fill commands checked
// against a queue of expected framebuffer writes, plus busy/abort sequences.
module tb_hub75_rect_fill;

    localparam logic [31:0] RB = 32'h8200_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata, rdata, m_addr, m_wdata;
    logic [3:0]  wmask, m_wmask;
    logic        wen, ren, ready, active, m_wen, m_ready, done;

    hub75_rect_fill #(
        .ROWS     (64),
        .COLS     (64),
        .FB_BASE  (32'h8100_0000),
        .REG_BASE (32'h8200_0000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .wdata   (wdata),
        .wmask   (wmask),
        .wen     (wen),
        .ren     (ren),
        .rdata   (rdata),
        .ready   (ready),
        .active  (active),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wmask (m_wmask),
        .m_wen   (m_wen),
        .m_ready (m_ready),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } wr_t;

    typedef struct {
        logic [7:0]  x0, y0, w, h;
        logic [23:0] color;
        logic        bufsel, swap;
        int          delay;
        int          exp_n;
        logic [31:0] exp_first;
    } vec_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    vec_t        vecs[9];
    int          checks = 0, failures = 0;
    int          wen_cnt = 0, done_cnt = 0, rsp_delay = 0;
    logic        first_pend = 1'b0;
    logic [31:0] first_addr = 32'd0;
    logic        outst = 1'b0, prev_wen = 1'b0, prev_done = 1'b0;
    logic [31:0] last_a = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each m_wen, checks WAIT stability and pulse widths
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            outst = 1'b0; prev_wen = 1'b0; prev_done = 1'b0;
        end else begin
            if (m_ready) outst = 1'b0;
            if (m_wen) begin
                wen_cnt++;
                chk("wen_single_cycle", 32'(prev_wen), 32'd0);
                if (first_pend) begin
                    first_addr = m_addr;
                    first_pend = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=0x%08h data=0x%08h required=none",
                             m_addr, m_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("m_addr", m_addr, mon_e.a);
                    chk("m_wdata", m_wdata, mon_e.d);
                    chk("m_wmask", 32'(m_wmask), 32'(mon_e.m));
                end
                outst  = 1'b1;
                last_a = m_addr;
            end else if (outst) begin
                chk("addr_stable_in_wait", m_addr, last_a);
            end
            if (done) begin
                done_cnt++;
                chk("done_single_cycle", 32'(prev_done), 32'd0);
            end
            prev_wen  = m_wen;
            prev_done = done;
        end
    end

    // Responder: m_ready for one cycle, rsp_delay cycles after the cycle following m_wen
    initial begin
        int cnt;
        cnt     = 0;
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            m_ready = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) m_ready = 1'b1;
            end
            if (m_wen) cnt = rsp_delay + 1;
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        addr = a; wdata = d; wmask = m; wen = 1'b1;
        @(posedge clk);
        #1;
        wen = 1'b0;
        chk("write_ready", 32'(ready), 32'd1);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; ren = 1'b1;
        @(posedge clk);
        #1;
        ren = 1'b0;
        d   = rdata;
        chk("read_ready", 32'(ready), 32'd1);
    endtask

    task automatic push_model(input vec_t v);
        int xe, ye;
        wr_t e;
        xe = int'(v.x0) + int'(v.w);
        ye = int'(v.y0) + int'(v.h);
        if (xe > 64) xe = 64;
        if (ye > 64) ye = 64;
        for (int y = int'(v.y0); y < ye; y++) begin
            for (int x = int'(v.x0); x < xe; x++) begin
                e.a = 32'h8100_0000 + 32'(4 * (int'(v.bufsel) * 4096 + y * 64 + x));
                e.d = {8'h00, v.color};
                e.m = 4'h7;
                exp_q.push_back(e);
            end
        end
        if (v.swap) begin
            e.a = 32'h8100_8000;
            e.d = {31'd0, v.bufsel};
            e.m = 4'hF;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            if (done_cnt != d0) break;
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic load_regs(input vec_t v);
        rsp_delay = v.delay;
        bus_write(RB + 32'd0, {16'd0, v.y0, v.x0}, 4'hF);
        bus_write(RB + 32'd4, {16'd0, v.h, v.w}, 4'hF);
        bus_write(RB + 32'd8, {8'd0, v.color}, 4'hF);
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int w0, d0;
        load_regs(v);
        push_model(v);
        w0 = wen_cnt;
        d0 = done_cnt;
        first_pend = 1'b1;
        bus_write(RB + 32'd12, {29'd0, v.swap, v.bufsel, 1'b1}, 4'hF);
        wait_done(d0);
        chk({tag, "_writes"}, 32'(wen_cnt - w0), 32'(v.exp_n));
        chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        if (v.exp_n > 0) chk({tag, "_first_addr"}, first_addr, v.exp_first);
        exp_q.delete();
        first_pend = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        vec_t v;
        int w0, d0;

        // x0 y0 w h color buf swap delay exp_n exp_first
        vecs[0] = '{8'd2,  8'd3,   8'd2,   8'd2, 24'h112233, 1'b0, 1'b0, 0, 4, 32'h8100_0308};
        vecs[1] = '{8'd62, 8'd63,  8'd5,   8'd5, 24'hABCDEF, 1'b0, 1'b0, 0, 2, 32'h8100_3FF8};
        vecs[2] = '{8'd5,  8'd5,   8'd0,   8'd4, 24'h123456, 1'b1, 1'b1, 0, 1, 32'h8100_8000};
        vecs[3] = '{8'd10, 8'd20,  8'd3,   8'd2, 24'h00FF00, 1'b1, 1'b0, 3, 6, 32'h8100_5428};
        vecs[4] = '{8'd64, 8'd0,   8'd4,   8'd4, 24'h0000FF, 1'b0, 1'b0, 0, 0, 32'h0};
        vecs[5] = '{8'd0,  8'd200, 8'd4,   8'd4, 24'hFF0000, 1'b0, 1'b1, 2, 1, 32'h8100_8000};
        vecs[6] = '{8'd0,  8'd0,   8'd3,   8'd1, 24'h777777, 1'b1, 1'b1, 1, 4, 32'h8100_4000};
        vecs[7] = '{8'd7,  8'd7,   8'd9,   8'd0, 24'h010203, 1'b0, 1'b0, 0, 0, 32'h0};
        vecs[8] = '{8'd60, 8'd2, 8'd255,   8'd1, 24'h0A0B0C, 1'b0, 1'b0, 0, 4, 32'h8100_02F0};

        rst_n = 1'b0;
        addr = 32'd0; wdata = 32'd0; wmask = 4'd0; wen = 1'b0; ren = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_m_wen", 32'(m_wen), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wmask", 32'(m_wmask), 32'd0);
        rst_n = 1'b1;

        // address decode window
        addr = RB;                #1; chk("active_base", 32'(active), 32'd1);
        addr = RB + 32'd15;       #1; chk("active_top", 32'(active), 32'd1);
        addr = RB + 32'd16;       #1; chk("active_past", 32'(active), 32'd0);
        addr = RB - 32'd1;        #1; chk("active_below", 32'(active), 32'd0);

        bus_read(RB + 32'd12, d);
        chk("ctrl_after_reset", d, 32'd0);

        for (int i = 0; i < 9; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

        // busy lockout and sticky done
        bus_read(RB + 32'd12, d);
        chk("sticky_set_before_clear", d & 32'h100, 32'h100);
        v = '{8'd2, 8'd3, 8'd2, 8'd2, 24'h445566, 1'b0, 1'b1, 3, 5, 32'h8100_0308};
        load_regs(v);
        push_model(v);
        w0 = wen_cnt;
        d0 = done_cnt;
        bus_write(RB + 32'd12, 32'h5, 4'hF);
        bus_read(RB + 32'd12, d);
        chk("ctrl_busy", d, 32'h0000_0005);
        bus_write(RB + 32'd0, 32'h0000_0909, 4'hF);
        bus_write(RB + 32'd12, 32'h3, 4'hF);
        bus_read(RB + 32'd12, d);
        chk("ctrl_busy_after_restart", d, 32'h0000_0005);
        wait_done(d0);
        chk("busy_cmd_writes", 32'(wen_cnt - w0), 32'd5);
        chk("busy_cmd_done", 32'(done_cnt - d0), 32'd1);
        chk("busy_cmd_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        bus_read(RB + 32'd0, d);
        chk("pos_unchanged", d, 32'h0000_0302);
        bus_read(RB + 32'd12, d);
        chk("ctrl_done_sticky", d, 32'h0000_0104);
        bus_read(RB + 32'd12, d);
        chk("ctrl_sticky_cleared", d, 32'h0000_0004);

        // byte masks on COLOR and SIZE readback
        bus_write(RB + 32'd8, 32'h00AA_BBCC, 4'hF);
        bus_write(RB + 32'd8, 32'h0011_2233, 4'b0010);
        bus_read(RB + 32'd8, d);
        chk("color_masked", d, 32'h00AA_22CC);
        bus_write(RB + 32'd4, 32'h0000_0504, 4'b0001);
        bus_read(RB + 32'd4, d);
        chk("size_masked", d, 32'h0000_0204);

        // reset in the middle of a command
        v = '{8'd0, 8'd0, 8'd2, 8'd2, 24'h0F0F0F, 1'b0, 1'b0, 3, 4, 32'h8100_0000};
        load_regs(v);
        push_model(v);
        w0 = wen_cnt;
        bus_write(RB + 32'd12, 32'h1, 4'hF);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (wen_cnt - w0 >= 2) break;
        end
        chk("abort_reached_pixel2", 32'(wen_cnt - w0), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_m_wen", 32'(m_wen), 32'd0);
        chk("abort_m_addr", m_addr, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        w0 = wen_cnt;
        d0 = done_cnt;
        repeat (30) @(posedge clk);
        #2;
        chk("abort_no_more_writes", 32'(wen_cnt - w0), 32'd0);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        bus_read(RB + 32'd12, d);
        chk("abort_ctrl_zero", d, 32'd0);
        bus_read(RB + 32'd0, d);
        chk("abort_pos_zero", d, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
